// File: rtl/div_share_ctrl_pkg.sv
// Shared types and defaults for the divider-sharing controller.
// DIV_WIDTH is the operand width also used by the attached div_int.
package div_share_ctrl_pkg;

    localparam int DIV_WIDTH   = 4;
    localparam int DIV_N_REQ   = 4;
    localparam int DIV_TIMEOUT = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } div_ctrl_state_t;

    // Round-robin successor of a requester index, wrapping at n.
    function automatic int next_id(input int id, input int n);
        return (id >= n - 1) ? 0 : id + 1;
    endfunction

endpackage

// File: rtl/div_share_ctrl_if.sv
// Requester, response and divider-side signals of div_share_ctrl.
// The controller uses the slave view; clients plus div_int form the master view.
interface div_share_ctrl_if
    import div_share_ctrl_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int N_REQ = DIV_N_REQ
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_x;
    logic [N_REQ*WIDTH-1:0] req_y;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [WIDTH-1:0]       rsp_q;
    logic [WIDTH-1:0]       rsp_r;
    logic                   rsp_dbz;
    logic                   rsp_err;

    logic                   div_start;
    logic [WIDTH-1:0]       div_x;
    logic [WIDTH-1:0]       div_y;
    logic                   div_busy;
    logic                   div_valid;
    logic                   div_dbz;
    logic [WIDTH-1:0]       div_q;
    logic [WIDTH-1:0]       div_r;

    modport slave (
        input  req_valid, req_x, req_y, rsp_ready,
        input  div_busy, div_valid, div_dbz, div_q, div_r,
        output req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dbz, rsp_err,
        output div_start, div_x, div_y
    );

    modport master (
        output req_valid, req_x, req_y, rsp_ready,
        output div_busy, div_valid, div_dbz, div_q, div_r,
        input  req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dbz, rsp_err,
        input  div_start, div_x, div_y
    );

endinterface

// File: rtl/div_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first active request at or
// after ptr, wrapping around N.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]          req,
    input  logic [$clog2(N)-1:0]  ptr,
    output logic [N-1:0]          gnt_onehot,
    output logic [$clog2(N)-1:0]  gnt_idx,
    output logic                  any
);
    localparam int IW = $clog2(N);

    int idx;

    // Scan from the farthest candidate back to ptr so the nearest one wins last.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = |req;
        idx        = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                gnt_onehot      = '0;
                gnt_onehot[idx] = 1'b1;
                gnt_idx         = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/div_share_ctrl.sv
// Shares one div_int among N_REQ requesters: round-robin grant, issue, wait
// for completion or timeout, then hold the tagged response until accepted.
module div_share_ctrl
    import div_share_ctrl_pkg::*;
#(
    parameter int WIDTH   = DIV_WIDTH,
    parameter int N_REQ   = DIV_N_REQ,
    parameter int TIMEOUT = DIV_TIMEOUT
) (
    input  logic            clk,
    input  logic            rst_n,
    div_share_ctrl_if.slave bus
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);
    // Counter value in the last WAIT cycle, so rsp_valid rises TIMEOUT cycles after div_start.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

    div_ctrl_state_t  state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             err_q, err_d;
    logic             seen_q, seen_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [N_REQ-1:0] gnt_onehot;
    logic [ID_W-1:0]  gnt_idx;
    logic             gnt_any;
    logic [N_REQ-1:0] ready_c;
    logic             done;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req        (bus.req_valid),
        .ptr        (ptr_q),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (gnt_any)
    );

    // A result counts only after busy was seen, unless the divider flags divide-by-zero.
    assign done = (seen_q && !bus.div_busy && bus.div_valid) || bus.div_dbz;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        x_d     = x_q;
        y_d     = y_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        err_d   = err_q;
        seen_d  = seen_q;
        cnt_d   = cnt_q;
        ready_c = '0;
        unique case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    ready_c = gnt_onehot;
                    x_d     = bus.req_x[int'(gnt_idx)*WIDTH +: WIDTH];
                    y_d     = bus.req_y[int'(gnt_idx)*WIDTH +: WIDTH];
                    id_d    = gnt_idx;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                seen_d  = 1'b0;
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.div_busy) begin
                    seen_d = 1'b1;
                end
                cnt_d = cnt_q + 1'b1;
                if (done) begin
                    quo_d   = bus.div_q;
                    rem_d   = bus.div_r;
                    dbz_d   = bus.div_dbz;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    quo_d   = '0;
                    rem_d   = '0;
                    dbz_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    ptr_d   = ID_W'(next_id(int'(id_q), N_REQ));
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            err_q   <= 1'b0;
            seen_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            x_q     <= x_d;
            y_q     <= y_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            err_q   <= err_d;
            seen_q  <= seen_d;
            cnt_q   <= cnt_d;
        end
    end

    // Grants are suppressed while reset is held so no client sees a false accept.
    assign bus.req_ready = rst_n ? ready_c : '0;
    assign bus.div_start = (state_q == ISSUE);
    assign bus.div_x     = x_q;
    assign bus.div_y     = y_q;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_q     = quo_q;
    assign bus.rsp_r     = rem_q;
    assign bus.rsp_dbz   = dbz_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_div_share_ctrl.sv
// Scoreboard bench for div_share_ctrl with a behavioural div_int stand-in.
// Expected responses are queued at stimulus time and popped by a monitor.
module tb_div_share_ctrl;
    import div_share_ctrl_pkg::*;

    localparam int W   = 4;
    localparam int N   = 4;
    localparam int TO  = 64;
    localparam int LAT = 5;

    typedef struct {
        int id;
        int q;
        int r;
        int dbz;
        int err;
        bit chk_qr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    div_share_ctrl_if #(.WIDTH(W), .N_REQ(N)) bus ();

    div_share_ctrl #(.WIDTH(W), .N_REQ(N), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   n_start = 0;
    int   n_rsp = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   rise_cyc = 0;
    bit   rsp_prev = 1'b0;
    bit   stub = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Behavioural divider: busy for LAT+1 cycles, then a one-cycle valid.
    bit             m_active = 1'b0;
    int             m_cnt = 0;
    logic [W-1:0]   m_q, m_r;
    initial begin
        bus.div_busy  = 1'b0;
        bus.div_valid = 1'b0;
        bus.div_dbz   = 1'b0;
        bus.div_q     = '0;
        bus.div_r     = '0;
        forever begin
            @(posedge clk);
            bus.div_valid <= 1'b0;
            bus.div_dbz   <= 1'b0;
            if (bus.div_start) begin
                if (stub) begin
                    bus.div_busy <= 1'b1;
                    m_active = 1'b0;
                end else if (bus.div_y == '0) begin
                    bus.div_busy <= 1'b0;
                    bus.div_dbz  <= 1'b1;
                    bus.div_q    <= '0;
                    bus.div_r    <= '0;
                    m_active = 1'b0;
                end else begin
                    bus.div_busy <= 1'b1;
                    m_q = bus.div_x / bus.div_y;
                    m_r = bus.div_x % bus.div_y;
                    m_cnt = LAT;
                    m_active = 1'b1;
                end
            end else if (m_active) begin
                if (m_cnt == 0) begin
                    bus.div_busy  <= 1'b0;
                    bus.div_valid <= 1'b1;
                    bus.div_q     <= m_q;
                    bus.div_r     <= m_r;
                    m_active = 1'b0;
                end else begin
                    m_cnt--;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every accepted response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.div_start) begin
                n_start++;
                start_cyc = cyc;
            end
            if (bus.rsp_valid && !rsp_prev) rise_cyc = cyc;
            rsp_prev = bus.rsp_valid;
            if (bus.rsp_valid && bus.rsp_ready && rst_n) begin
                n_rsp++;
                if (sbq.size() == 0) begin
                    chk("unexpected_rsp", 32'(bus.rsp_id), 32'hFFFF_FFFF);
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
                    chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                    chk("rsp_dbz", 32'(bus.rsp_dbz), 32'(e.dbz));
                    if (e.chk_qr) begin
                        chk("rsp_q", 32'(bus.rsp_q), 32'(e.q));
                        chk("rsp_r", 32'(bus.rsp_r), 32'(e.r));
                    end
                end
            end
            cyc++;
        end
    end

    // One clock; requests accepted in this cycle are withdrawn afterwards.
    task automatic tick();
        logic [N-1:0] hs;
        @(negedge clk);
        hs = bus.req_valid & bus.req_ready;
        @(posedge clk);
        #1;
        bus.req_valid = bus.req_valid & ~hs;
    endtask

    task automatic req(input int i, input int x, input int y);
        bus.req_x[i*W +: W] = W'(x);
        bus.req_y[i*W +: W] = W'(y);
        bus.req_valid[i]    = 1'b1;
    endtask

    task automatic push(input int id, input int q, input int r, input int dbz, input int err, input bit cq);
        exp_t e;
        e.id = id; e.q = q; e.r = r; e.dbz = dbz; e.err = err; e.chk_qr = cq;
        sbq.push_back(e);
    endtask

    task automatic drain(input string nm, input int budget);
        int n = 0;
        while (sbq.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk(nm, 32'(sbq.size()), 32'd0);
        sbq.delete();
    endtask

    task automatic chk_all_zero(input string nm);
        chk(nm, {bus.req_ready, bus.rsp_valid, bus.div_start, bus.div_x, bus.div_y,
                 bus.rsp_id, bus.rsp_q, bus.rsp_r, bus.rsp_dbz, bus.rsp_err}, 32'd0);
    endtask

    initial begin
        int s0, r0, n;
        bus.req_valid = '0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        bus.rsp_ready = 1'b1;
        rst_n = 1'b0;
        req(0, 13, 4);
        tick();
        tick();
        chk_all_zero("reset_outputs");

        // Single request
        push(0, 3, 1, 0, 0, 1'b1);
        s0 = n_start;
        rst_n = 1'b1;
        drain("t1_drain", 50);
        chk("t1_start_pulses", 32'(n_start - s0), 32'd1);

        // Wrap the pointer back to 0 through requester 3
        req(3, 12, 5);
        push(3, 2, 2, 0, 0, 1'b1);
        drain("wrap_drain", 50);

        // All four held, two rounds
        for (int round = 0; round < 2; round++) begin
            req(0, 7, 2);  req(1, 9, 3);  req(2, 15, 1);  req(3, 8, 5);
            push(0, 3, 1, 0, 0, 1'b1);
            push(1, 3, 0, 0, 0, 1'b1);
            push(2, 15, 0, 0, 0, 1'b1);
            push(3, 1, 3, 0, 0, 1'b1);
            drain("t2_drain", 200);
        end

        // Divide by zero
        req(2, 6, 0);
        push(2, 0, 0, 1, 0, 1'b0);
        drain("t3_drain", 50);

        // Backpressure
        bus.rsp_ready = 1'b0;
        req(0, 5, 2);
        n = 0;
        while (!bus.rsp_valid && n < 50) begin
            tick();
            n++;
        end
        chk("t4_rsp_seen", 32'(bus.rsp_valid), 32'd1);
        req(1, 14, 3);
        req(3, 0, 7);
        s0 = n_start;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("t4_rsp_stable", {bus.rsp_valid, bus.rsp_id, bus.rsp_q, bus.rsp_r,
                                  bus.rsp_dbz, bus.rsp_err}, {1'b1, 2'd0, 4'd2, 4'd1, 1'b0, 1'b0});
            chk("t4_req_ready", 32'(bus.req_ready), 32'd0);
        end
        chk("t4_no_start", 32'(n_start - s0), 32'd0);
        push(0, 2, 1, 0, 0, 1'b1);
        push(1, 4, 2, 0, 0, 1'b1);
        push(3, 0, 0, 0, 0, 1'b1);
        bus.rsp_ready = 1'b1;
        drain("t4_drain", 100);

        // Timeout with a divider that never answers
        stub = 1'b1;
        req(1, 9, 2);
        push(1, 0, 0, 0, 1, 1'b1);
        drain("t5_drain", 200);
        chk("t5_latency", 32'(rise_cyc - start_cyc), 32'(TO));
        stub = 1'b0;

        // Reset while waiting on the divider
        s0 = n_start;
        req(1, 10, 3);
        n = 0;
        while (n_start == s0 && n < 20) begin
            tick();
            n++;
        end
        chk("t6_started", 32'(n_start - s0), 32'd1);
        tick();
        rst_n = 1'b0;
        tick();
        chk_all_zero("t6_reset_outputs");
        rst_n = 1'b1;
        r0 = n_rsp;
        for (int k = 0; k < 20; k++) tick();
        chk("t6_no_rsp", 32'(n_rsp - r0), 32'd0);
        req(3, 10, 3);
        push(3, 3, 1, 0, 0, 1'b1);
        drain("t6_drain", 50);

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
